// File: rtl/sgt_argmax_seq.sv
// Sequential signed arg-max over valid/ready framed words, sharing one coreir_sgt comparator.
// Optional `SGT_ARGMAX_COUNT_EN adds the O_count output (words in the completed frame).

module coreir_sgt #(
  parameter int width = 1
) (
  input  logic [width-1:0] in0,
  input  logic [width-1:0] in1,
  output logic             out
);
  assign out = $signed(in0) > $signed(in1);
endmodule

module sgt_argmax_seq #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I_valid,
  output logic             I_ready,
  input  logic [WIDTH-1:0] I_data,
  input  logic             I_last,
  output logic             O_valid,
  input  logic             O_ready,
  output logic [WIDTH-1:0] O_max,
  output logic [IDX_W-1:0] O_idx,
  output logic             O_trunc
`ifdef SGT_ARGMAX_COUNT_EN
  ,
  output logic [IDX_W:0]   O_count
`endif
);

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    ACC   = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Index of the final word a frame may hold before it is force-terminated.
  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'((1 << IDX_W) - 1);

  state_t           state_r, state_nxt;
  logic [WIDTH-1:0] max_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W:0]   cnt_r;
  logic             trunc_r;
  logic             gt;

  coreir_sgt #(.width(WIDTH)) u_sgt (
    .in0 (I_data),
    .in1 (max_r),
    .out (gt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge CLK) begin
    if (RESET) state_r <= FIRST;
    else       state_r <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state_r;
    I_ready   = 1'b0;
    O_valid   = 1'b0;
    case (state_r)
      FIRST: begin
        I_ready = 1'b1;
        if (I_valid) state_nxt = I_last ? OUT : ACC;
      end
      ACC: begin
        I_ready = 1'b1;
        if (I_valid && (I_last || cnt_r == LAST_IDX)) state_nxt = OUT;
      end
      OUT: begin
        O_valid = 1'b1;
        if (O_ready) state_nxt = FIRST;
      end
      default: state_nxt = FIRST;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      max_r   <= '0;
      idx_r   <= '0;
      cnt_r   <= '0;
      trunc_r <= 1'b0;
    end else begin
      case (state_r)
        FIRST: if (I_valid) begin
          max_r   <= I_data;
          idx_r   <= '0;
          cnt_r   <= (IDX_W+1)'(1);
          trunc_r <= 1'b0;
        end
        ACC: if (I_valid) begin
          // Strictly greater only, so ties keep the earlier index.
          if (gt) begin
            max_r <= I_data;
            idx_r <= cnt_r[IDX_W-1:0];
          end
          cnt_r <= cnt_r + 1'b1;
          if (!I_last && cnt_r == LAST_IDX) trunc_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign O_max   = max_r;
  assign O_idx   = idx_r;
  assign O_trunc = trunc_r;
`ifdef SGT_ARGMAX_COUNT_EN
  assign O_count = cnt_r;
`endif

endmodule

// File: tb/tb_sgt_argmax_seq.sv
// Directed bench for sgt_argmax_seq: a WIDTH=4/IDX_W=4 instance and an IDX_W=2
// instance for truncation; honours `SGT_ARGMAX_COUNT_EN when defined.

module tb_sgt_argmax_seq;

  logic       clk = 1'b0;
  logic       reset;
  int         checks = 0;
  int         errors = 0;

  // Main instance, WIDTH=4, IDX_W=4.
  logic       i_valid, i_ready, i_last, o_valid, o_ready, o_trunc;
  logic [3:0] i_data, o_max, o_idx;
  // Truncation instance, WIDTH=4, IDX_W=2.
  logic       i_valid2, i_ready2, i_last2, o_valid2, o_ready2, o_trunc2;
  logic [3:0] i_data2, o_max2;
  logic [1:0] o_idx2;
`ifdef SGT_ARGMAX_COUNT_EN
  logic [4:0] o_count;
  logic [2:0] o_count2;
`endif

  always #5 clk = ~clk;

  sgt_argmax_seq #(.WIDTH(4), .IDX_W(4)) dut (
    .CLK(clk), .RESET(reset),
    .I_valid(i_valid), .I_ready(i_ready), .I_data(i_data), .I_last(i_last),
    .O_valid(o_valid), .O_ready(o_ready), .O_max(o_max), .O_idx(o_idx),
    .O_trunc(o_trunc)
`ifdef SGT_ARGMAX_COUNT_EN
    , .O_count(o_count)
`endif
  );

  sgt_argmax_seq #(.WIDTH(4), .IDX_W(2)) dut2 (
    .CLK(clk), .RESET(reset),
    .I_valid(i_valid2), .I_ready(i_ready2), .I_data(i_data2), .I_last(i_last2),
    .O_valid(o_valid2), .O_ready(o_ready2), .O_max(o_max2), .O_idx(o_idx2),
    .O_trunc(o_trunc2)
`ifdef SGT_ARGMAX_COUNT_EN
    , .O_count(o_count2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word to the main instance for exactly one edge.
  task automatic send(input logic [3:0] d, input logic last);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    check("i_ready_before_accept", i_ready, 1);
    step();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic send2(input logic [3:0] d, input logic last);
    i_valid2 = 1'b1;
    i_data2  = d;
    i_last2  = last;
    step();
    i_valid2 = 1'b0;
    i_last2  = 1'b0;
  endtask

  task automatic result(input string tag, input logic [3:0] m, input logic [3:0] idx,
                        input logic [4:0] cnt);
    check({tag, "_valid"}, o_valid, 1);
    check({tag, "_ready_low"}, i_ready, 0);
    check({tag, "_max"}, o_max, m);
    check({tag, "_idx"}, o_idx, idx);
    check({tag, "_trunc"}, o_trunc, 0);
`ifdef SGT_ARGMAX_COUNT_EN
    check({tag, "_count"}, o_count, cnt);
`else
    if (cnt == 5'd0) check({tag, "_cnt_arg"}, cnt, 1);
`endif
  endtask

  initial begin
    reset = 1'b1;
    i_valid = 0; i_data = 0; i_last = 0; o_ready = 1;
    i_valid2 = 0; i_data2 = 0; i_last2 = 0; o_ready2 = 1;
    step(); step();
    reset = 1'b0;

    check("rst_i_ready", i_ready, 1);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_max", o_max, 0);
    check("rst_o_idx", o_idx, 0);
    check("rst_o_trunc", o_trunc, 0);
`ifdef SGT_ARGMAX_COUNT_EN
    check("rst_o_count", o_count, 0);
`endif

    // [3, -2, 7, -8]: max 7 at index 2.
    send(4'h3, 0); send(4'hE, 0); send(4'h7, 0); send(4'h8, 1);
    result("basic", 4'h7, 4'd2, 5'd4);
    step();
    check("basic_drop", o_valid, 0);

    // [-1, 2]: signed compare must pick 2.
    send(4'hF, 0); send(4'h2, 1);
    result("signed", 4'h2, 4'd1, 5'd2);
    step();

    // [5, 5, 5]: tie keeps first index.
    send(4'h5, 0); send(4'h5, 0); send(4'h5, 1);
    result("tie", 4'h5, 4'd0, 5'd3);
    step();

    // [-8] alone.
    send(4'h8, 1);
    result("single", 4'h8, 4'd0, 5'd1);
    step();

    // Backpressure: [1, 6] then hold O_ready low with a new word waiting.
    o_ready = 1'b0;
    send(4'h1, 0); send(4'h6, 1);
    i_valid = 1'b1; i_data = 4'h3; i_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      result("stall", 4'h6, 4'd1, 5'd2);
      step();
    end
    result("stall_end", 4'h6, 4'd1, 5'd2);
    o_ready = 1'b1;
    step();
    check("bp_first_ready", i_ready, 1);
    check("bp_first_valid", o_valid, 0);
    step();
    i_valid = 1'b0; i_last = 1'b0;
    result("bp_next", 4'h3, 4'd0, 5'd1);
    step();

    // Reset mid-frame discards partial state.
    send(4'h7, 0); send(4'h6, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_o_valid", o_valid, 0);
    check("midrst_o_max", o_max, 0);
    check("midrst_i_ready", i_ready, 1);
    send(4'hD, 1);
    result("after_rst", 4'hD, 4'd0, 5'd1);
    step();
    check("after_rst_drop", o_valid, 0);

    // Truncation on the IDX_W=2 instance: [1, 4, 2, 0] without last.
    send2(4'h1, 0); send2(4'h4, 0); send2(4'h2, 0);
    check("trunc_not_yet", o_valid2, 0);
    send2(4'h0, 0);
    check("trunc_valid", o_valid2, 1);
    check("trunc_max", o_max2, 4'h4);
    check("trunc_idx", o_idx2, 2'd1);
    check("trunc_flag", o_trunc2, 1);
`ifdef SGT_ARGMAX_COUNT_EN
    check("trunc_count", o_count2, 3'd4);
`endif
    check("trunc_ready_low", i_ready2, 0);
    // Word 6 waits through OUT and then opens a new frame at index 0.
    i_valid2 = 1'b1; i_data2 = 4'h6; i_last2 = 1'b1;
    step();
    check("trunc_back_first", o_valid2, 0);
    step();
    i_valid2 = 1'b0; i_last2 = 1'b0;
    check("next_valid", o_valid2, 1);
    check("next_max", o_max2, 4'h6);
    check("next_idx", o_idx2, 2'd0);
    check("next_trunc", o_trunc2, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
